// File: rtl/imem_stream.sv
// Registered-read instruction memory with a 2-entry response buffer and range checking.
// Define IMEM_LOADER_EN to build the streaming program loader (LOAD state and write port).
module imem_stream #(
    parameter int    WIDTH     = 32,
    parameter int    DEPTH     = 64,
    parameter int    AW        = 8,
    parameter string INIT_FILE = "memfile.dat"
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW-1:0]    req_addr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    input  logic             load_start,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    output logic             load_done
);
    localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    logic [WIDTH-1:0] mem [DEPTH];

    state_t           state_q, state_d;
    logic [MW-1:0]    ptr_q, ptr_d;
    logic             load_done_q, load_done_d;
    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    logic             err0_q, err0_d, err1_q, err1_d;
    logic             push_s, pop_s, in_range_s, wr_en_s;
    logic [WIDTH-1:0] rd_data_s;
    logic [MW-1:0]    wr_addr_s;

    // Slot 0 is always the buffer head, so the outputs come straight from flops.
    assign req_ready = (state_q == ST_RUN) && (count_q < 2'd2);
    assign rsp_valid = (count_q != 2'd0);
    assign rsp_data  = data0_q;
    assign rsp_err   = err0_q;
    assign load_done = load_done_q;
    assign push_s    = req_valid && req_ready;
    assign pop_s     = rsp_valid && rsp_ready;

    // Array lookup with out-of-range addresses forced to zero data
    always_comb begin
        in_range_s = (32'(req_addr) < 32'(DEPTH));
        rd_data_s  = '0;
        if (in_range_s) begin
            rd_data_s = mem[req_addr[MW-1:0]];
        end else begin
            rd_data_s = '0;
        end
    end

    // Response buffer next state: shift on pop, fill first free slot on push
    always_comb begin
        count_d = count_q;
        data0_d = data0_q;
        data1_d = data1_q;
        err0_d  = err0_q;
        err1_d  = err1_q;
        case ({push_s, pop_s})
            2'b10: begin
                if (count_q == 2'd0) begin
                    data0_d = rd_data_s;
                    err0_d  = ~in_range_s;
                end else begin
                    data1_d = rd_data_s;
                    err1_d  = ~in_range_s;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                data0_d = data1_q;
                err0_d  = err1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    data0_d = rd_data_s;
                    err0_d  = ~in_range_s;
                end else begin
                    data0_d = data1_q;
                    err0_d  = err1_q;
                    data1_d = rd_data_s;
                    err1_d  = ~in_range_s;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

`ifdef IMEM_LOADER_EN
    // Loader control: a start restarts at word 0 and may carry a word in the same cycle
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        load_done_d = 1'b0;
        wr_en_s     = 1'b0;
        wr_addr_s   = ptr_q;
        if (load_start || (state_q == ST_LOAD)) begin
            wr_addr_s = load_start ? {MW{1'b0}} : ptr_q;
            if (load_valid) begin
                wr_en_s = 1'b1;
                if (load_last || (wr_addr_s == MW'(DEPTH - 1))) begin
                    state_d     = ST_RUN;
                    ptr_d       = {MW{1'b0}};
                    load_done_d = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                    ptr_d   = wr_addr_s + {{(MW-1){1'b0}}, 1'b1};
                end
            end else begin
                state_d = ST_LOAD;
                ptr_d   = wr_addr_s;
            end
        end else begin
            state_d = ST_RUN;
        end
    end
`else
    logic unused_load_s;
    assign unused_load_s = ^{load_start, load_valid, load_last, ptr_q, state_q};

    // ROM build: loader inputs have no effect and the state never leaves RUN
    always_comb begin
        state_d     = ST_RUN;
        ptr_d       = {MW{1'b0}};
        load_done_d = 1'b0;
        wr_en_s     = 1'b0;
        wr_addr_s   = {MW{1'b0}};
    end
`endif

    // Memory write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_en_s && !reset) begin
            mem[wr_addr_s] <= load_data;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            ptr_q       <= {MW{1'b0}};
            load_done_q <= 1'b0;
            count_q     <= 2'd0;
            data0_q     <= '0;
            data1_q     <= '0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            load_done_q <= load_done_d;
            count_q     <= count_d;
            data0_q     <= data0_d;
            data1_q     <= data1_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
        end
    end
endmodule

// File: tb/tb_imem_stream.sv
// Self-checking bench for imem_stream: queue-based reference model plus directed literal checks.
module tb_imem_stream;
    localparam int WIDTH = 32;
    localparam int DEPTH = 64;
    localparam int AW    = 8;
`ifdef IMEM_LOADER_EN
    localparam bit LOADER = 1'b1;
`else
    localparam bit LOADER = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic [AW-1:0]    req_addr = '0;
    logic             rsp_ready = 1'b0;
    logic             load_start = 1'b0;
    logic             load_valid = 1'b0;
    logic [WIDTH-1:0] load_data = '0;
    logic             load_last = 1'b0;
    logic             req_ready, rsp_valid, rsp_err, load_done;
    logic [WIDTH-1:0] rsp_data;

    imem_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .INIT_FILE("")) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_done(load_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: memory image, response queue, loader state
    typedef struct packed { logic err; logic [WIDTH-1:0] data; } rsp_t;
    logic [WIDTH-1:0] m_mem [DEPTH];
    rsp_t m_q[$];
    bit   m_load = 1'b0;
    int   m_ptr = 0;
    bit   m_done = 1'b0;
    bit   started = 1'b0;

    typedef struct { int cyc; logic err; logic [WIDTH-1:0] data; } got_t;
    got_t got[$];

    initial begin : model
        bit   rdy;
        rsp_t item;
        int   wa;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_q.delete();
                m_load = 1'b0;
                m_ptr  = 0;
                m_done = 1'b0;
            end else begin
                rdy       = !m_load && (m_q.size() < 2);
                item.err  = (int'(req_addr) >= DEPTH);
                item.data = item.err ? '0 : m_mem[req_addr];
                if (m_q.size() > 0 && rsp_ready) void'(m_q.pop_front());
                if (req_valid && rdy) m_q.push_back(item);
                m_done = 1'b0;
                if (LOADER && (load_start || m_load)) begin
                    wa = load_start ? 0 : m_ptr;
                    if (load_valid) begin
                        m_mem[wa] = load_data;
                        if (load_last || wa == DEPTH - 1) begin
                            m_load = 1'b0;
                            m_ptr  = 0;
                            m_done = 1'b1;
                        end else begin
                            m_load = 1'b1;
                            m_ptr  = wa + 1;
                        end
                    end else begin
                        m_load = 1'b1;
                        m_ptr  = wa;
                    end
                end
            end
            started = 1'b1;
        end
    end

    // Record every response the DUT hands over
    initial begin : logger
        forever begin
            @(posedge clk);
            if (!reset && rsp_valid && rsp_ready)
                got.push_back('{int'($time / 10), rsp_err, rsp_data});
        end
    end

    // Cycle-by-cycle comparison against the model
    initial begin : compare
        forever begin
            @(negedge clk);
            if (started) begin
                check("req_ready", req_ready, !m_load && (m_q.size() < 2));
                check("rsp_valid", rsp_valid, m_q.size() > 0);
                if (m_q.size() > 0) begin
                    check("rsp_data", rsp_data, m_q[0].data);
                    check("rsp_err", rsp_err, m_q[0].err);
                end
                check("load_done", load_done, m_done);
            end
        end
    end

    task automatic send(input logic [AW-1:0] a);
        int k;
        req_valid = 1'b1;
        req_addr  = a;
        k = 0;
        while (!req_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("send_accept", k < 100, 1'b1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_got(input string name, input logic [WIDTH-1:0] d, input logic e);
        got_t g;
        check({name, "_present"}, got.size() > 0, 1'b1);
        if (got.size() > 0) begin
            g = got.pop_front();
            check({name, "_data"}, g.data, d);
            check({name, "_err"}, g.err, e);
        end
    endtask

    initial begin : stim
        logic [WIDTH-1:0] w;
        int c0;
        for (int i = 0; i < DEPTH; i++) begin
            w = 32'h11111111 * 32'(i % 16);
            m_mem[i]   = w;
            dut.mem[i] = w;
        end
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_load_done", load_done, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back reads of words 0..3
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(AW'(i));
        idle(4);
        c0 = (got.size() > 0) ? got[0].cyc : 0;
        for (int i = 0; i < 4; i++) begin
            if (got.size() > 0) check("b2b_cycle", got[0].cyc - c0, 64'(i));
            expect_got("b2b", 32'h11111111 * 32'(i), 1'b0);
        end

        // Out-of-range then a normal read
        send(8'd64);
        send(8'd1);
        idle(3);
        expect_got("oor", 32'h00000000, 1'b1);
        expect_got("after_oor", 32'h11111111, 1'b0);

        // Back-pressure: two buffered, third waits for a pop
        rsp_ready = 1'b0;
        send(8'd5);
        send(8'd6);
        check("full_ready", req_ready, 1'b0);
        req_valid = 1'b1;
        req_addr  = 8'd7;
        repeat (3) begin
            @(negedge clk);
            check("stall_data", rsp_data, 32'h55555555);
            check("stall_ready", req_ready, 1'b0);
        end
        check("stall_nopop", got.size(), 0);
        rsp_ready = 1'b1;
        send(8'd7);
        idle(4);
        expect_got("order0", 32'h55555555, 1'b0);
        expect_got("order1", 32'h66666666, 1'b0);
        expect_got("order2", 32'h77777777, 1'b0);

        // Program load of two words
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        check("load_ready0", req_ready, !LOADER);
        load_valid = 1'b1;
        load_data  = 32'hDEADBEEF;
        @(negedge clk);
        check("load_ready1", req_ready, !LOADER);
        check("load_done_early", load_done, 1'b0);
        load_data = 32'hCAFEF00D;
        load_last = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("load_done_pulse", load_done, LOADER);
        check("load_ready_back", req_ready, 1'b1);
        @(negedge clk);
        check("load_done_clear", load_done, 1'b0);
        send(8'd0);
        send(8'd1);
        send(8'd2);
        idle(4);
        expect_got("ld0", LOADER ? 32'hDEADBEEF : 32'h00000000, 1'b0);
        expect_got("ld1", LOADER ? 32'hCAFEF00D : 32'h11111111, 1'b0);
        expect_got("ld2", 32'h22222222, 1'b0);

        // Reset in the middle of a load
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data  = 32'h12345678;
        @(negedge clk);
        load_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_ready", req_ready, 1'b1);
        check("mid_rst_done", load_done, 1'b0);
        @(negedge clk);
        check("mid_rst_done2", load_done, 1'b0);
        send(8'd0);
        idle(3);
        expect_got("mid_rst_rd", LOADER ? 32'h12345678 : 32'h00000000, 1'b0);

        // Reset with two responses buffered
        rsp_ready = 1'b0;
        send(8'd2);
        send(8'd3);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_flush_valid", rsp_valid, 1'b0);
        check("rst_flush_ready", req_ready, 1'b1);
        rsp_ready = 1'b1;
        check("rst_flush_lost", got.size(), 0);
        send(8'd3);
        idle(3);
        expect_got("rst_keep3", 32'h33333333, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
